freq_calc: RTL and testbench

- Consumer of the equal-precision gate counts (standard-clock count cnt_s, signal count cnt_x).
- On each completed measurement it computes freq_hz = round(cnt_x * CLK_FREQ_HZ / cnt_s) with a multi-cycle sequential divider.
- Presents the result with a one-cycle valid pulse.
- Sits between the measurement gate and the display/UART reporting logic on the 100 MHz domain.

---
 rtl/freq_meter_pkg.sv | 16 +
 rtl/udiv_seq.sv | 72 +++++++
 rtl/freq_calc.sv | 128 ++++++++++++
 tb/tb_freq_calc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM states and
// arithmetic constants common to the gate and calculation blocks.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  localparam int unsigned CLK_FREQ_HZ_DEF = 100_000_000;
  localparam int unsigned DIV_ITER        = 64;
  localparam int unsigned ITER_W          = $clog2(DIV_ITER);

endpackage

// File: rtl/udiv_seq.sv
// 64-by-32 sequential restoring divider, one quotient bit per cycle.
// The start cycle performs iteration 0, so done_o marks the final step.
module udiv_seq
  import freq_meter_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [63:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [63:0] quot_o,
  output logic [31:0] rem_o
);

  logic              run_q;
  logic [ITER_W-1:0] cnt_q;
  logic [63:0]       num_q, num_d;
  logic [63:0]       quo_q, quo_d;
  logic [31:0]       rem_q, rem_d;

  logic [63:0] num_src;
  logic [63:0] quo_src;
  logic [31:0] rem_src;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        ge;
  logic        step;

  always_comb begin
    num_src = start_i ? dividend_i : num_q;
    quo_src = start_i ? 64'd0 : quo_q;
    rem_src = start_i ? 32'd0 : rem_q;
    trial   = {rem_src, num_src[63]};
    diff    = trial - {1'b0, divisor_i};
    ge      = trial >= {1'b0, divisor_i};
    // A non-restored trial is below the divisor, so bit 32 is zero.
    rem_d   = ge ? diff[31:0] : trial[31:0];
    num_d   = {num_src[62:0], 1'b0};
    quo_d   = {quo_src[62:0], ge};
    step    = start_i | run_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      num_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      if (step) begin
        num_q <= num_d;
        quo_q <= quo_d;
        rem_q <= rem_d;
      end
      if (start_i) begin
        run_q <= 1'b1;
        cnt_q <= ITER_W'(1);
      end else if (run_q) begin
        cnt_q <= cnt_q + ITER_W'(1);
        if (done_o)
          run_q <= 1'b0;
      end
    end
  end

  assign done_o = run_q && (cnt_q == ITER_W'(DIV_ITER - 1));
  assign quot_o = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/freq_calc.sv
// Converts equal-precision gate counts into a rounded frequency in Hz,
// freq = round(cnt_x * CLK_FREQ_HZ / cnt_s), with saturation.
module freq_calc
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
  parameter int unsigned OUT_W       = 32
) (
  input  logic             clk_100M,
  input  logic             rst_n,
  input  logic             meas_gate,
  input  logic [31:0]      cnt_s,
  input  logic [31:0]      cnt_x,
  output logic             busy,
  output logic             freq_valid,
  output logic [OUT_W-1:0] freq_hz,
  output logic             err_zero,
  output logic             overflow,
  output logic             dropped
);

  localparam logic [63:0] CLK64 = 64'(CLK_FREQ_HZ);
  localparam logic [64:0] SAT   = (65'd1 << OUT_W) - 65'd1;

  state_e           state_q;
  logic             gate_pre_q;
  logic [31:0]      cs_q, cx_q;
  logic [63:0]      num_q;
  logic             start_q;
  logic             busy_q;
  logic             valid_q;
  logic [OUT_W-1:0] freq_q;
  logic             err_zero_q;
  logic             overflow_q;
  logic             dropped_q;

  logic        fall;
  logic        div_done;
  logic [63:0] quot;
  logic [31:0] rem;
  logic        round_up;
  logic [64:0] q_r;
  logic        sat;

  udiv_seq u_div (
    .clk_i      (clk_100M),
    .rst_ni     (rst_n),
    .start_i    (start_q),
    .dividend_i (num_q),
    .divisor_i  (cs_q),
    .done_o     (div_done),
    .quot_o     (quot),
    .rem_o      (rem)
  );

  always_comb begin
    fall     = gate_pre_q & ~meas_gate;
    round_up = {1'b0, rem, 1'b0} >= {2'b00, cs_q};
    q_r      = {1'b0, quot} + 65'(round_up);
    sat      = q_r > SAT;
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gate_pre_q <= 1'b0;
      cs_q       <= '0;
      cx_q       <= '0;
      num_q      <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      freq_q     <= '0;
      err_zero_q <= 1'b0;
      overflow_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      gate_pre_q <= meas_gate;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      dropped_q  <= fall && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            cs_q <= cnt_s;
            cx_q <= cnt_x;
            // Zero divisor reports at once without entering the datapath.
            if (cnt_s == 32'd0) begin
              freq_q     <= '1;
              err_zero_q <= 1'b1;
              overflow_q <= 1'b0;
              valid_q    <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= MUL;
            end
          end
        end
        MUL: begin
          num_q   <= 64'(cx_q) * CLK64;
          start_q <= 1'b1;
          state_q <= DIV;
        end
        DIV: begin
          if (div_done)
            state_q <= DONE;
        end
        DONE: begin
          err_zero_q <= 1'b0;
          overflow_q <= sat;
          freq_q     <= sat ? '1 : q_r[OUT_W-1:0];
          valid_q    <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign freq_valid = valid_q;
  assign freq_hz    = freq_q;
  assign err_zero   = err_zero_q;
  assign overflow   = overflow_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_freq_calc.sv
// Scoreboard bench for freq_calc: directed and random gate falls,
// checked against an arithmetic reference model.
module tb_freq_calc;

  localparam longint unsigned FCLK = 100_000_000;
  localparam longint unsigned MAXO = 64'hFFFF_FFFF;

  logic        clk_100M = 1'b0;
  logic        rst_n    = 1'b0;
  logic        meas_gate = 1'b0;
  logic [31:0] cnt_s = '0;
  logic [31:0] cnt_x = '0;
  logic        busy, freq_valid, err_zero, overflow, dropped;
  logic [31:0] freq_hz;

  always #5 clk_100M = ~clk_100M;

  freq_calc dut (
    .clk_100M   (clk_100M),
    .rst_n      (rst_n),
    .meas_gate  (meas_gate),
    .cnt_s      (cnt_s),
    .cnt_x      (cnt_x),
    .busy       (busy),
    .freq_valid (freq_valid),
    .freq_hz    (freq_hz),
    .err_zero   (err_zero),
    .overflow   (overflow),
    .dropped    (dropped)
  );

  typedef struct {
    logic [31:0] f;
    bit          ez;
    bit          ov;
    int unsigned due;
  } exp_t;

  exp_t        expq[$];
  int unsigned dropq[$];
  int unsigned cyc = 0;
  int unsigned next_free = 0;
  int unsigned bstart = 1;
  int unsigned bend = 0;
  int          checks = 0;
  int          passed = 0;

  always @(posedge clk_100M) cyc++;

  task automatic chk(input string name, input longint unsigned act,
                     input longint unsigned req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                  name, act, req, cyc);
  endtask

  function automatic exp_t model(input logic [31:0] s, input logic [31:0] x);
    exp_t e;
    longint unsigned num, q, r;
    e.ez = 0;
    e.ov = 0;
    e.due = 0;
    if (s == 0) begin
      e.f  = '1;
      e.ez = 1;
    end else begin
      num = longint'(x) * FCLK;
      q = num / s;
      r = num % s;
      if (2 * r >= longint'(s)) q++;
      if (q > MAXO) begin
        e.f  = '1;
        e.ov = 1;
      end else begin
        e.f = q[31:0];
      end
    end
    return e;
  endfunction

  task automatic fall(input logic [31:0] s, input logic [31:0] x);
    exp_t e;
    int unsigned t;
    @(negedge clk_100M);
    meas_gate = 1'b1;
    @(negedge clk_100M);
    cnt_s = s;
    cnt_x = x;
    meas_gate = 1'b0;
    t = cyc;
    if (t >= next_free) begin
      e = model(s, x);
      e.due = t + ((s == 0) ? 1 : 67);
      next_free = e.due;
      expq.push_back(e);
      if (s != 0) begin
        bstart = t + 1;
        bend = t + 66;
      end
    end else begin
      dropq.push_back(t + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_100M);
  endtask

  always @(negedge clk_100M) begin
    exp_t e;
    int unsigned d;
    if (rst_n) begin
      chk("busy", busy, (cyc >= bstart && cyc <= bend));
      if (freq_valid) begin
        if (expq.size() == 0) begin
          chk("valid_unexpected", freq_valid, 0);
        end else begin
          e = expq.pop_front();
          chk("latency", cyc, e.due);
          chk("freq_hz", freq_hz, e.f);
          chk("err_zero", err_zero, e.ez);
          chk("overflow", overflow, e.ov);
        end
      end
      if (dropped) begin
        if (dropq.size() == 0) begin
          chk("drop_unexpected", dropped, 0);
        end else begin
          d = dropq.pop_front();
          chk("drop_cycle", cyc, d);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, freq_valid, 0);
    chk({tag, "_freq"}, freq_hz, 0);
    chk({tag, "_ezero"}, err_zero, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_drop"}, dropped, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, x;
    int sel;

    #12;
    check_reset_outputs("reset");
    @(negedge clk_100M);
    rst_n = 1'b1;
    idle(3);

    fall(32'd10_000_000, 32'd1000); idle(70);
    fall(32'd3, 32'd1);             idle(70);
    fall(32'd3, 32'd2);             idle(70);
    fall(32'd1, 32'd100);           idle(70);
    fall(32'd0, 32'd5);             idle(5);
    fall(32'd512, 32'd1);           idle(70);
    fall(32'd1, 32'd42);            idle(70);
    fall(32'd1, 32'd43);            idle(70);

    fall(32'd7, 32'd1);
    idle(17);
    fall(32'd9, 32'd9);
    idle(70);

    fall(32'd11, 32'd13);
    idle(64);
    fall(32'd5, 32'd5);
    idle(70);

    fall(32'd5, 32'd123);
    idle(32);
    #2;
    rst_n = 1'b0;
    expq.delete();
    dropq.delete();
    next_free = 0;
    bend = 0;
    #1;
    check_reset_outputs("abort");
    idle(2);
    #2;
    rst_n = 1'b1;
    idle(2);
    fall(32'd4, 32'd1);
    idle(70);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      x = $urandom;
      if (sel == 0) s = 0;
      else if (sel == 1) begin
        s = 1;
        x = $urandom_range(40, 45);
      end else if (sel == 2) s = $urandom_range(1, 20);
      else s = $urandom;
      if (sel == 3) x = $urandom_range(0, 1000);
      fall(s, x);
      idle($urandom_range(0, 80));
    end

    for (int i = 0; i < 200; i++) begin
      if (expq.size() == 0 && dropq.size() == 0) break;
      @(negedge clk_100M);
    end
    chk("drain_results", expq.size(), 0);
    chk("drain_drops", dropq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
